// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM encoding and reset defaults for the dead-time PWM generator
package pwm_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SOFTSTART = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } pwm_state_e;
    localparam int DEF_PERIOD  = 400;
    localparam int DEF_DT      = 10;
    localparam int DEF_SS_STEP = 4;
endpackage

// File: rtl/pwm_dt_chan.sv
// pwm_dt_chan: per-channel duty clamp, compare and dead-time windows with registered gates
module pwm_dt_chan #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gate_i,
    input  logic [W-1:0] cnt_i,
    input  logic [W-1:0] duty_i,
    input  logic [W-1:0] cap_i,
    input  logic [W-1:0] lim_i,
    input  logic [W-1:0] post_i,
    input  logic [W-1:0] hi_i,
    output logic         pwm_o,
    output logic         sec_o
);
    logic [W-1:0] duty_m, duty_eff;
    logic         pwm_d, pwm_q, sec_d, sec_q;
    // duty_eff <= lim keeps duty_eff + post inside the period, so the sum cannot wrap
    always_comb begin
        duty_m   = (duty_i < cap_i) ? duty_i : cap_i;
        duty_eff = (duty_m < lim_i) ? duty_m : lim_i;
        pwm_d    = gate_i && (cnt_i < duty_eff);
        sec_d    = gate_i && (cnt_i >= duty_eff + post_i) && (cnt_i < hi_i);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= 1'b0;
            sec_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
            sec_q <= sec_d;
        end
    end
    assign pwm_o = pwm_q;
    assign sec_o = sec_q;
endmodule

// File: rtl/pwm_gen_dt.sv
// pwm_gen_dt: multi-channel PWM with shared period counter, dead-time, soft-start,
// fault latch and shadowed configuration committed at period wrap.
module pwm_gen_dt
    import pwm_pkg::*;
#(
    parameter int NCH            = 2,
    parameter int CNT_WIDTH      = 16,
    parameter int PERIOD_DEFAULT = DEF_PERIOD,
    parameter int DT_DEFAULT     = DEF_DT,
    parameter int SS_STEP        = DEF_SS_STEP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     fault,
    input  logic                     fault_clr,
    input  logic                     upd,
    input  logic [CNT_WIDTH-1:0]     period_in,
    input  logic [NCH*CNT_WIDTH-1:0] duty_in,
    input  logic [CNT_WIDTH-1:0]     dt_pre_in,
    input  logic [CNT_WIDTH-1:0]     dt_post_in,
    output logic [NCH-1:0]           pwm_out,
    output logic [NCH-1:0]           secondary_out,
    output logic                     upd_done,
    output logic                     cfg_err,
    output logic                     period_start,
    output logic [1:0]               state
);
    localparam int W  = CNT_WIDTH;
    localparam int CW = 3*W + NCH*W;
    localparam logic [CW-1:0] CFG_RST = {W'(PERIOD_DEFAULT), W'(DT_DEFAULT), W'(DT_DEFAULT), {NCH*W{1'b0}}};

    pwm_state_e       state_q, state_d;
    logic [W-1:0]     cnt_q, cnt_d, ramp_q, ramp_d;
    logic [CW-1:0]    act_q, act_d, sh_q, sh_d;
    logic             pending_q, pending_d, done_q, err_q, ps_q;
    logic [W-1:0]     per_a, pre_a, post_a, duty_max, cap, lim, hi;
    logic [NCH*W-1:0] duty_a;
    logic [W:0]       ramp_sum;
    logic             run_q, gate, wrap, cfg_ok, load, commit;

    assign {per_a, pre_a, post_a, duty_a} = act_q;
    assign run_q  = (state_q == SOFTSTART) || (state_q == RUN);
    assign wrap   = run_q && (cnt_q == per_a - W'(1));
    assign cfg_ok = (period_in >= W'(4)) && ({1'b0, dt_pre_in} + {1'b0, dt_post_in} < {1'b0, period_in});
    assign load   = upd && cfg_ok;
    assign commit = pending_q && (wrap || (state_q == IDLE));
    // gating on the next state too makes en/fault drop the gates on the very next edge
    assign gate   = run_q && ((state_d == SOFTSTART) || (state_d == RUN));
    assign cap    = (state_q == RUN) ? '1 : ramp_q;
    assign lim    = per_a - pre_a - post_a;
    assign hi     = per_a - pre_a;

    always_comb begin
        duty_max = '0;
        for (int k = 0; k < NCH; k++)
            duty_max = (duty_a[k*W +: W] > duty_max) ? duty_a[k*W +: W] : duty_max;
        state_d = state_q;
        if (fault) state_d = FAULT;
        else begin
            case (state_q)
                IDLE:      state_d = en ? SOFTSTART : IDLE;
                SOFTSTART: state_d = !en ? IDLE : (wrap && ramp_q >= duty_max) ? RUN : SOFTSTART;
                RUN:       state_d = en ? RUN : IDLE;
                default:   state_d = fault_clr ? IDLE : FAULT;
            endcase
        end
    end

    always_comb begin
        ramp_sum  = {1'b0, ramp_q} + (W+1)'(SS_STEP);
        ramp_d    = (state_q == IDLE) ? '0 :
                    (state_q == SOFTSTART && wrap) ? (ramp_sum[W] ? '1 : ramp_sum[W-1:0]) : ramp_q;
        cnt_d     = (!gate || wrap) ? '0 : cnt_q + W'(1);
        sh_d      = load ? {period_in, dt_pre_in, dt_post_in, duty_in} : sh_q;
        act_d     = commit ? sh_q : act_q;
        pending_d = load || (pending_q && !commit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ramp_q    <= '0;
            act_q     <= CFG_RST;
            sh_q      <= CFG_RST;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ps_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ramp_q    <= ramp_d;
            act_q     <= act_d;
            sh_q      <= sh_d;
            pending_q <= pending_d;
            done_q    <= commit;
            err_q     <= upd && !cfg_ok;
            ps_q      <= gate && (cnt_q == '0);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        pwm_dt_chan #(.W(W)) u_chan (
            .clk    (clk),
            .rst    (rst),
            .gate_i (gate),
            .cnt_i  (cnt_q),
            .duty_i (duty_a[c*W +: W]),
            .cap_i  (cap),
            .lim_i  (lim),
            .post_i (post_a),
            .hi_i   (hi),
            .pwm_o  (pwm_out[c]),
            .sec_o  (secondary_out[c])
        );
    end

    assign upd_done     = done_q;
    assign cfg_err      = err_q;
    assign period_start = ps_q;
    assign state        = state_q;
endmodule

// File: tb/tb_pwm_gen_dt.sv
// tb_pwm_gen_dt: scenario bench; expected gate patterns per period are queued from the
// spec formulas and popped against the DUT each cycle, aligned on period_start.
module tb_pwm_gen_dt;
    localparam int NCH = 2;
    localparam int W   = 16;

    logic           clk = 1'b0;
    logic           rst, en, fault, fault_clr, upd;
    logic [W-1:0]   period_in, dt_pre_in, dt_post_in;
    logic [2*W-1:0] duty_in;
    logic [1:0]     pwm_out, secondary_out, state;
    logic           upd_done, cfg_err, period_start;
    int             n_pass = 0;
    int             n_total = 0;
    logic [4:0]     exp_q[$];

    always #5 clk = ~clk;

    pwm_gen_dt #(.NCH(NCH), .CNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .fault(fault), .fault_clr(fault_clr), .upd(upd),
        .period_in(period_in), .duty_in(duty_in), .dt_pre_in(dt_pre_in), .dt_post_in(dt_post_in),
        .pwm_out(pwm_out), .secondary_out(secondary_out), .upd_done(upd_done),
        .cfg_err(cfg_err), .period_start(period_start), .state(state)
    );

    // one entry per cycle: {period_start, secondary[1:0], pwm[1:0]}
    function automatic void push_period(input int p, input int pre, input int post,
                                        input int d0, input int d1, input int cap);
        for (int c = 0; c < p; c++) begin
            logic [4:0] e;
            int ek;
            e = '0;
            e[4] = (c == 0);
            for (int k = 0; k < 2; k++) begin
                ek = (k == 0) ? d0 : d1;
                if (cap < ek) ek = cap;
                if (p - pre - post < ek) ek = p - pre - post;
                e[k]   = c < ek;
                e[2+k] = (c >= ek + post) && (c < p - pre);
            end
            exp_q.push_back(e);
        end
    endfunction

    task automatic do_upd(input int p, input int pre, input int post, input int d0, input int d1);
        period_in  = W'(p);
        dt_pre_in  = W'(pre);
        dt_post_in = W'(post);
        duty_in    = {W'(d1), W'(d0)};
        upd        = 1'b1;
        @(negedge clk);
        upd        = 1'b0;
    endtask

    task automatic sync_start(input int budget, output bit ok, output int dn);
        ok = 1'b0;
        dn = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = period_start;
            dn += int'(upd_done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; fault = 1'b0; fault_clr = 1'b0; upd = 1'b0;
        period_in = '0; duty_in = '0; dt_pre_in = '0; dt_post_in = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({state, pwm_out, secondary_out, upd_done, cfg_err, period_start} !== 9'b0)
            $display("FAIL reset_hold got %b want 0", {state, pwm_out, secondary_out, upd_done, cfg_err, period_start});
        else n_pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({state, pwm_out, secondary_out, period_start} !== 7'b0)
            $display("FAIL reset_idle got %b want 0", {state, pwm_out, secondary_out, period_start});
        else n_pass++;
    endtask

    task automatic test_basic;
        logic [4:0] e;
        bit ok;
        int dn;
        do_upd(10, 1, 1, 4, 6);
        @(negedge clk);
        n_total++;
        if (upd_done !== 1'b1) $display("FAIL basic_upd_done got %b want 1", upd_done);
        else n_pass++;
        en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = (state == 2'd2);
        end
        n_total++;
        if (!ok) $display("FAIL basic_reach_run got state %0d want 2", state);
        else n_pass++;
        sync_start(20, ok, dn);
        n_total++;
        if (!ok) $display("FAIL basic_sync got no period_start want pulse");
        else n_pass++;
        push_period(10, 1, 1, 4, 6, 65535);
        for (int c = 0; c < 10 && ok; c++) begin
            if (c > 0) @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if ({period_start, secondary_out, pwm_out} !== e || (pwm_out & secondary_out) != 2'b0)
                $display("FAIL basic_c%0d got %b want %b", c, {period_start, secondary_out, pwm_out}, e);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_update;
        logic [4:0] e;
        bit ok;
        int dn;
        repeat (3) @(negedge clk);
        do_upd(20, 1, 1, 4, 6);
        sync_start(30, ok, dn);
        n_total++;
        if (!ok) $display("FAIL upd_sync got no period_start want pulse");
        else n_pass++;
        push_period(20, 1, 1, 4, 6, 65535);
        for (int c = 0; c < 20 && ok; c++) begin
            if (c > 0) @(negedge clk);
            dn += int'(upd_done);
            e = exp_q.pop_front();
            n_total++;
            if ({period_start, secondary_out, pwm_out} !== e)
                $display("FAIL upd_p20_c%0d got %b want %b", c, {period_start, secondary_out, pwm_out}, e);
            else n_pass++;
        end
        exp_q.delete();
        n_total++;
        if (dn != 1) $display("FAIL upd_done_count got %0d want 1", dn);
        else n_pass++;
        repeat (2) @(negedge clk);
        do_upd(12, 1, 1, 4, 6);
        do_upd(10, 1, 1, 9, 3);
        sync_start(30, ok, dn);
        push_period(10, 1, 1, 9, 3, 65535);
        for (int c = 0; c < 10 && ok; c++) begin
            if (c > 0) @(negedge clk);
            dn += int'(upd_done);
            e = exp_q.pop_front();
            n_total++;
            if ({period_start, secondary_out, pwm_out} !== e)
                $display("FAIL b2b_clamp_c%0d got %b want %b", c, {period_start, secondary_out, pwm_out}, e);
            else n_pass++;
        end
        exp_q.delete();
        n_total++;
        if (!ok || dn != 1) $display("FAIL b2b_done_count got %0d sync %0d want 1 sync 1", dn, ok);
        else n_pass++;
        do_upd(3, 1, 1, 5, 5);
        n_total++;
        if (cfg_err !== 1'b1) $display("FAIL err_short_period got %b want 1", cfg_err);
        else n_pass++;
        do_upd(10, 5, 5, 5, 5);
        n_total++;
        if (cfg_err !== 1'b1) $display("FAIL err_dead_time got %b want 1", cfg_err);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (cfg_err !== 1'b0) $display("FAIL err_pulse_width got %b want 0", cfg_err);
        else n_pass++;
        sync_start(30, ok, dn);
        push_period(10, 1, 1, 9, 3, 65535);
        for (int c = 0; c < 10 && ok; c++) begin
            if (c > 0) @(negedge clk);
            dn += int'(upd_done);
            e = exp_q.pop_front();
            n_total++;
            if ({period_start, secondary_out, pwm_out} !== e)
                $display("FAIL rejected_c%0d got %b want %b", c, {period_start, secondary_out, pwm_out}, e);
            else n_pass++;
        end
        exp_q.delete();
        n_total++;
        if (!ok || dn != 0) $display("FAIL rejected_no_commit got %0d sync %0d want 0 sync 1", dn, ok);
        else n_pass++;
    endtask

    task automatic test_softstart;
        logic [4:0] e;
        bit ok;
        int dn;
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_total++;
        if ({state, pwm_out, secondary_out} !== 6'b0)
            $display("FAIL en_off got %b want 0", {state, pwm_out, secondary_out});
        else n_pass++;
        do_upd(20, 1, 1, 12, 12);
        @(negedge clk);
        n_total++;
        if (upd_done !== 1'b1) $display("FAIL idle_commit got %b want 1", upd_done);
        else n_pass++;
        en = 1'b1;
        for (int r = 0; r <= 12; r += 4) begin
            sync_start(40, ok, dn);
            n_total++;
            if (!ok || state !== 2'd1) $display("FAIL ss_state_r%0d got %0d sync %0d want 1 sync 1", r, state, ok);
            else n_pass++;
            push_period(20, 1, 1, 12, 12, r);
            for (int c = 0; c < 20 && ok; c++) begin
                if (c > 0) @(negedge clk);
                e = exp_q.pop_front();
                n_total++;
                if ({period_start, secondary_out, pwm_out} !== e)
                    $display("FAIL ss_r%0d_c%0d got %b want %b", r, c, {period_start, secondary_out, pwm_out}, e);
                else n_pass++;
            end
            exp_q.delete();
        end
        @(negedge clk);
        n_total++;
        if (state !== 2'd2 || period_start !== 1'b1)
            $display("FAIL ss_to_run got state %0d ps %b want 2 1", state, period_start);
        else n_pass++;
    endtask

    task automatic test_fault;
        repeat (2) @(negedge clk);
        fault = 1'b1;
        @(negedge clk);
        n_total++;
        if ({state, pwm_out, secondary_out} !== {2'd3, 4'b0})
            $display("FAIL fault_entry got %b want 110000", {state, pwm_out, secondary_out});
        else n_pass++;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        @(negedge clk);
        n_total++;
        if (state !== 2'd3) $display("FAIL fault_clr_ignored got %0d want 3", state);
        else n_pass++;
        fault = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({state, pwm_out, secondary_out, period_start} !== {2'd3, 5'b0})
            $display("FAIL fault_held got %b want 1100000", {state, pwm_out, secondary_out, period_start});
        else n_pass++;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        n_total++;
        if (state !== 2'd0) $display("FAIL fault_release got %0d want 0", state);
        else n_pass++;
    endtask

    task automatic test_reset_run;
        bit ok;
        int dn, len, ns, np;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (state == 2'd2);
        end
        repeat (3) @(negedge clk);
        n_total++;
        if (!ok || pwm_out !== 2'b11) $display("FAIL rr_pre got pwm %b run %0d want 11 1", pwm_out, ok);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({state, pwm_out, secondary_out} !== 6'b0)
            $display("FAIL rr_async_drop got %b want 0", {state, pwm_out, secondary_out});
        else n_pass++;
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({state, pwm_out, secondary_out} !== 6'b0)
            $display("FAIL rr_idle got %b want 0", {state, pwm_out, secondary_out});
        else n_pass++;
        en = 1'b1;
        sync_start(20, ok, dn);
        len = 0; ns = 0; np = 0;
        if (ok) begin
            do begin
                ns += int'(secondary_out[0]);
                np += int'(|pwm_out);
                len++;
                @(negedge clk);
            end while (!period_start && len < 450);
        end
        n_total++;
        if (len != 400) $display("FAIL rr_default_period got %0d want 400", len);
        else n_pass++;
        n_total++;
        if (ns != 380 || np != 0) $display("FAIL rr_default_dt got sec %0d pwm %0d want 380 0", ns, np);
        else n_pass++;
        n_total++;
        if (state !== 2'd2) $display("FAIL rr_zero_duty_run got %0d want 2", state);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_update();
        test_softstart();
        test_fault();
        test_reset_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pwm_gen_dt.md
PWM_GEN_DT -- requirements
Module: pwm_gen_dt

Interface
REQ-001 SHALL have parameter NCH, default 2: number of PWM channels sharing one period counter.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of period, duty and dead-time values.
REQ-003 SHALL have parameter PERIOD_DEFAULT, default 400: active period after reset.
REQ-004 SHALL have parameter DT_DEFAULT, default 10: active pre and post dead-time after reset.
REQ-005 SHALL have parameter SS_STEP, default 4: soft-start ramp increment per period.
REQ-006 SHALL have ports, in this order:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  level; run request
- fault  input  1  level; forces outputs off
- fault_clr  input  1  pulse; clears latched fault
- upd  input  1  pulse; capture new configuration
- period_in  input  CNT_WIDTH  requested period, in clocks
- duty_in  input  NCH*CNT_WIDTH  requested on-time per channel, channel k at bits [k*W +: W]
- dt_pre_in, dt_post_in  input  CNT_WIDTH each  dead-time before/after primary on-time
- pwm_out  output  NCH  primary gate per channel
- secondary_out  output  NCH  complementary gate per channel
- upd_done  output  1  one-cycle pulse when the shadow is committed
- cfg_err  output  1  one-cycle pulse when upd is rejected
- period_start  output  1  one-cycle pulse at counter value 0 while running
- state  output  2  current FSM state

Function
REQ-007 SHALL run a counter cnt 0..period_act-1, wrapping to 0, in SOFTSTART/RUN only; cnt SHALL be held at 0 in IDLE/FAULT.
REQ-008 SHALL clamp duty: duty_eff[k] = min(duty_act[k], ramp, period_act - pre_act - post_act); ramp SHALL be ignored in RUN.
REQ-009 SHALL register outputs, one cycle latency from cnt:
- pwm_out[k] = 1 when cnt < duty_eff[k]
- secondary_out[k] = 1 when duty_eff[k] + post_act <= cnt < period_act - pre_act
REQ-010 SHALL never assert pwm_out[k] and secondary_out[k] in the same cycle.
REQ-011 On upd with period_in >= 4 and dt_pre_in + dt_post_in < period_in, SHALL load all inputs into the shadow and set pending.
REQ-012 SHALL reject an upd that fails REQ-011: pulse cfg_err, leave the shadow and pending unchanged.
REQ-013 SHALL copy shadow to active at cnt == period_act-1 while pending, or on any cycle in IDLE while pending; SHALL clear pending and pulse upd_done in the same cycle.
REQ-014 A second upd before commit SHALL overwrite the shadow, giving a single commit and a single upd_done.
REQ-015 An upd coinciding with a commit cycle SHALL commit the old shadow and leave the new one pending.
REQ-016 SHALL implement FSM states IDLE=0, SOFTSTART=1, RUN=2, FAULT=3.
REQ-017 IDLE->SOFTSTART when en=1 and fault=0; ramp SHALL be set to 0.
REQ-018 In SOFTSTART, ramp SHALL increase by SS_STEP at each wrap, saturating at the all-ones value.
REQ-019 SOFTSTART->RUN at the wrap where ramp >= max over k of duty_act[k].
REQ-020 SOFTSTART/RUN->IDLE when en=0; outputs SHALL be 0 on the next cycle.
REQ-021 Any state->FAULT when fault=1, with priority over en; outputs SHALL be 0 on the next cycle.
REQ-022 FAULT->IDLE only on fault_clr=1 with fault=0; fault_clr SHALL be ignored while fault=1.
REQ-023 period_start SHALL pulse only in SOFTSTART/RUN.

Reset
REQ-024 While rst=1, SHALL force:
- state=IDLE, cnt=0, ramp=0, pending=0
- all outputs 0
- period_act=PERIOD_DEFAULT, duty_act=0, pre_act=post_act=DT_DEFAULT, shadow equal to active
REQ-025 rst asserted mid-period SHALL drop all gates within the same cycle, asynchronously.

Structure
REQ-026 SHALL place the state encoding and the PERIOD_DEFAULT/DT_DEFAULT/SS_STEP defaults in shared package pwm_pkg.
REQ-027 SHALL instantiate NCH copies of sub-module pwm_dt_chan (duty clamp, compare, dead-time, output registers); the counter, FSM and shadow logic SHALL stay in the top level.

Verification
REQ-028 period=10, duty={4,6}, pre=post=1, RUN -> ch0 pwm cnt 0-3, sec 5-8; ch1 pwm 0-5, sec 7-8; never overlapping.
REQ-029 duty=9, period=10, pre=post=1 -> duty_eff=8: pwm cnt 0-7, secondary never high.
REQ-030 en rise with duty=12, SS_STEP=4 -> eff duty 0,4,8,12 on consecutive periods, then state=RUN.
REQ-031 upd at mid-period with period_in=20 -> new period from next cnt 0, one upd_done; upd with period_in=3 -> cfg_err, no change.
REQ-032 fault=1 mid-period -> outputs 0 next cycle, state=FAULT; fault_clr with fault=1 ignored; after fault=0 and fault_clr -> IDLE.
REQ-033 rst pulse during RUN -> outputs 0 immediately, defaults restored, state=IDLE.
